// File: rtl/moore_seq_det_param.sv
// moore_seq_det_param: run-time configurable Moore serial pattern detector.
// cs counts how many pattern prefix bits are currently matched; out is high in S(len).
// Optional match counter is built only when SEQ_DET_CNT_EN is defined; otherwise
// match_cnt is tied to zero and cnt_clr is ignored.
module moore_seq_det_param #(
    parameter int unsigned       PAT_W       = 8,
    parameter logic [PAT_W-1:0]  PAT_DEFAULT = PAT_W'(8'hD5),
    parameter int unsigned       CNT_W       = 8,
    localparam int unsigned      LEN_W       = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in,
    input  logic             in_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             out,
    output logic [LEN_W-1:0] cs,
    output logic [CNT_W-1:0] match_cnt
);

    logic [LEN_W-1:0] cs_q, cs_d;
    logic             out_q, out_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic             hit;

    // History including the bit on the input; bit[m] was received m bits ago.
    logic [PAT_W-1:0] hist_new;
    assign hist_new = {hist_q[PAT_W-2:0], in};

    logic unused_hist_msb;
    assign unused_hist_msb = hist_q[PAT_W-1];

    // Longest prefix length the next state may reach from the current state.
    logic             at_match;
    logic [LEN_W-1:0] limit;
    assign at_match = (cs_q == len_q);
    assign limit    = at_match ? (ovl_q ? len_q : LEN_W'(1)) : (cs_q + LEN_W'(1));

    // km[k-1]: the newest k bits equal pat[0..k-1]; evaluated for all k in parallel.
    logic [PAT_W-1:0] km;
    logic [PAT_W-1:0] km_ok;
    logic [LEN_W-1:0] best [PAT_W+1];
    assign best[0] = '0;

    for (genvar k = 1; k <= PAT_W; k++) begin : g_pre
        logic [k-1:0] bit_ok;
        for (genvar j = 0; j < k; j++) begin : g_bit
            assign bit_ok[j] = (pat_q[j] == hist_new[k-1-j]);
        end
        assign km[k-1]    = &bit_ok;
        assign km_ok[k-1] = km[k-1] && (LEN_W'(k) <= limit);
        // Priority chain: a longer matching prefix overrides a shorter one.
        assign best[k]    = km_ok[k-1] ? LEN_W'(k) : best[k-1];
    end

    // Next-state and configuration update; cfg_load takes priority over data.
    always_comb begin
        cs_d   = cs_q;
        out_d  = out_q;
        hist_d = hist_q;
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hit    = 1'b0;
        if (cfg_load) begin
            cs_d   = '0;
            out_d  = 1'b0;
            hist_d = '0;
            pat_d  = cfg_pat;
            len_d  = ((cfg_len == '0) || (cfg_len > LEN_W'(PAT_W))) ? LEN_W'(PAT_W) : cfg_len;
            ovl_d  = cfg_overlap;
        end else if (in_valid) begin
            cs_d   = best[PAT_W];
            hist_d = hist_new;
            hit    = (best[PAT_W] == len_q);
            out_d  = hit;
        end
    end

    // State and configuration registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cs_q   <= '0;
            out_q  <= 1'b0;
            hist_q <= '0;
            pat_q  <= PAT_DEFAULT;
            len_q  <= LEN_W'(PAT_W);
            ovl_q  <= 1'b1;
        end else begin
            cs_q   <= cs_d;
            out_q  <= out_d;
            hist_q <= hist_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
        end
    end

    assign out = out_q;
    assign cs  = cs_q;

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating match counter; clear wins over a simultaneous match.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_moore_seq_det_param.sv
// tb_moore_seq_det_param: directed vectors for moore_seq_det_param; a driver pushes
// hand-computed expectations into a queue, a monitor pops and compares them.
module tb_moore_seq_det_param;

    logic       clk = 1'b0;
    logic       rstn;
    logic       in_b;
    logic       in_valid;
    logic       cfg_load;
    logic [7:0] cfg_pat;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       cnt_clr;
    logic       out_b, out2_b;
    logic [3:0] cs_b, cs2_b;
    logic [7:0] cnt_b;
    logic [1:0] cnt2_b;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int step_id = 0;

    typedef struct {
        int         due;
        bit         imm;
        int         id;
        logic [3:0] cs;
        logic       out;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;

    moore_seq_det_param dut (
        .clk(clk), .rstn(rstn), .in(in_b), .in_valid(in_valid), .cfg_load(cfg_load),
        .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .out(out_b), .cs(cs_b), .match_cnt(cnt_b)
    );

    moore_seq_det_param #(.CNT_W(2)) dut2 (
        .clk(clk), .rstn(rstn), .in(in_b), .in_valid(in_valid), .cfg_load(cfg_load),
        .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .out(out2_b), .cs(cs2_b), .match_cnt(cnt2_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ec(input int v);
`ifdef SEQ_DET_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input int id, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s step %0d: got %0d expected %0d", name, id, act, exp);
    endtask

    task automatic push(input bit imm, input int due, input int ecs, input int eout, input int ecnt);
        exp_t e;
        step_id++;
        e.due  = due;
        e.imm  = imm;
        e.id   = step_id;
        e.cs   = 4'(ecs);
        e.out  = 1'(eout);
        e.cnt  = 8'(ec(ecnt));
        e.cnt2 = 2'(ec(ecnt > 3 ? 3 : ecnt));
        exp_q.push_back(e);
    endtask

    // Monitor: compares whenever an expectation falls due (clock) or is flagged immediate.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            while (exp_q.size() > 0 && (exp_q[0].imm || exp_q[0].due <= cyc)) begin
                e = exp_q.pop_front();
                chk("cs",    e.id, int'(cs_b),   int'(e.cs));
                chk("out",   e.id, int'(out_b),  int'(e.out));
                chk("cnt",   e.id, int'(cnt_b),  int'(e.cnt));
                chk("cnt_w2", e.id, int'(cnt2_b), int'(e.cnt2));
                chk("cs_w2", e.id, int'(cs2_b),  int'(e.cs));
            end
        end
    end

    task automatic set_idle();
        in_b = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic step(input logic b, input logic v, input logic ld, input logic clr,
                        input logic [7:0] p, input logic [3:0] l, input logic o,
                        input int ecs, input int eout, input int ecnt);
        @(posedge clk); #1;
        in_b = b; in_valid = v; cfg_load = ld; cnt_clr = clr;
        cfg_pat = p; cfg_len = l; cfg_overlap = o;
        push(1'b0, cyc + 1, ecs, eout, ecnt);
    endtask

    task automatic sb(input logic b, input int ecs, input int eout, input int ecnt);
        step(b, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, ecs, eout, ecnt);
    endtask

    task automatic idle(input int ecs, input int eout, input int ecnt);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, ecs, eout, ecnt);
    endtask

    task automatic ld(input logic [7:0] p, input logic [3:0] l, input logic o, input logic clr,
                      input logic b, input logic v, input int ecnt);
        step(b, v, 1'b1, clr, p, l, o, 0, 0, ecnt);
    endtask

    // Asynchronous reset mid-cycle; state must clear before the next clock edge.
    task automatic async_rst();
        @(posedge clk); #1;
        set_idle();
        @(negedge clk); #1;
        rstn = 1'b0;
        push(1'b1, cyc, 0, 0, 0);
        #1;
        ->chk_ev;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        cfg_pat = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
        set_idle();
        #3;
        push(1'b1, 0, 0, 0, 0);
        ->chk_ev;
        @(posedge clk); #1;
        rstn = 1'b1;

        // 1: default pattern, then one more bit falls back to S2
        sb(1,1,0,0); sb(0,2,0,0); sb(1,3,0,0); sb(0,4,0,0);
        sb(1,5,0,0); sb(0,6,0,0); sb(1,7,0,0); sb(1,8,1,1);
        sb(0,2,0,1);

        // 2: 101 overlapping, then non-overlapping
        ld(8'h05, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        sb(1,1,0,0); sb(0,2,0,0); sb(1,3,1,1); sb(0,2,0,1); sb(1,3,1,2);
        ld(8'h05, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        sb(1,1,0,0); sb(0,2,0,0); sb(1,3,1,1); sb(0,0,0,1); sb(1,1,0,1);

        // 3: default pattern with fallback 3 -> 1
        ld(8'hD5, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        sb(1,1,0,0); sb(0,2,0,0); sb(1,3,0,0); sb(1,1,0,0); sb(0,2,0,0); sb(1,3,0,0);
        sb(0,4,0,0); sb(1,5,0,0); sb(0,6,0,0); sb(1,7,0,0); sb(1,8,1,1);

        // 4: hold in S(len) and mid-pattern, load discards bit, length clamp
        idle(8,1,1); idle(8,1,1); idle(8,1,1);
        ld(8'hD5, 4'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1);
        sb(1,1,0,1); sb(0,2,0,1); sb(1,3,0,1);
        idle(3,0,1); idle(3,0,1); idle(3,0,1);
        sb(0,4,0,1); sb(1,5,0,1); sb(0,6,0,1); sb(1,7,0,1); sb(1,8,1,2);
        idle(8,1,2); idle(8,1,2); idle(8,1,2);
        ld(8'hD5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        sb(1,1,0,2); sb(0,2,0,2); sb(1,3,0,2); sb(0,4,0,2);
        sb(1,5,0,2); sb(0,6,0,2); sb(1,7,0,2); sb(1,8,1,3);

        // 5: len=1, counter saturation on the 2-bit instance, clear wins over match
        ld(8'h01, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        sb(1,1,1,1); sb(1,1,1,2); sb(0,0,0,2); sb(1,1,1,3); sb(1,1,1,4); sb(1,1,1,5);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0, 1, 1, 0);
        sb(1,1,1,1);

        // 6: async reset mid-pattern, and reset restores the default configuration
        ld(8'hD5, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        sb(1,1,0,1); sb(0,2,0,1); sb(1,3,0,1); sb(0,4,0,1); sb(1,5,0,1);
        async_rst();
        ld(8'h05, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        async_rst();
        sb(1,1,0,0); sb(0,2,0,0); sb(1,3,0,0); sb(0,4,0,0);
        sb(1,5,0,0); sb(0,6,0,0); sb(1,7,0,0); sb(1,8,1,1);

        @(posedge clk); #1;
        set_idle();
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
